// File: rtl/uart_xintf_bridge_pkg.sv
// Shared constants and state encodings for the UART <-> XINTF bridge.
package uart_xintf_bridge_pkg;

  localparam int unsigned U2X_FBYTE_NUM = 22;
  localparam int unsigned X2U_FBYTE_NUM = 6;
  localparam int unsigned BAUD_DIV      = 109;
  localparam int unsigned BAUD_MID      = 54;
  localparam int unsigned FIFO_DEPTH    = 64;
  localparam int unsigned CNT_W         = $clog2(FIFO_DEPTH + 1);

  localparam logic [7:0] FRAME_HEADER = 8'hAA;
  localparam logic [7:0] CSUM_SEED    = 8'hFF;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count; Depth must be a power of two.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 64,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic [CntW-1:0]  count,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             full, do_push, do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_xintf_bridge.sv
// UART (8N1) to XINTF bridge: checked 22-byte RX frames land in FIFO1 for the host,
// host writes collect in FIFO2 and leave over UART in 6-byte bursts.
module uart_xintf_bridge
  import uart_xintf_bridge_pkg::*;
(
  input  logic        clk50M,
  input  logic        rst_n,
  input  logic        uart_rxd,
  output logic        uart_txd,
  input  logic        xcs_n,
  input  logic        xrd,
  input  logic        xwe,
  inout  wire  [15:0] xdata,
  input  logic        c_xcs_n,
  output logic        c_xrd_req
);

  localparam logic [6:0]       BaudLast   = 7'(BAUD_DIV - 1);
  localparam logic [6:0]       BaudMid    = 7'(BAUD_MID);
  localparam logic [4:0]       FrameLast  = 5'(U2X_FBYTE_NUM - 1);
  localparam logic [CNT_W-1:0] FrameLen   = CNT_W'(U2X_FBYTE_NUM);
  localparam logic [CNT_W-1:0] Fifo1Room  = CNT_W'(FIFO_DEPTH - U2X_FBYTE_NUM);
  localparam logic [CNT_W-1:0] TxBurst    = CNT_W'(X2U_FBYTE_NUM);
  localparam logic [2:0]       TxLeftInit = 3'(X2U_FBYTE_NUM - 1);

  // Input synchronizers
  logic [1:0] rxd_sync_q, xcs_sync_q, xrd_sync_q, xwe_sync_q, cxcs_sync_q;
  logic [7:0] xd_sync1_q, xd_sync2_q;
  logic       rxd_s, xrd_s, xwe_s, xif_en;

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      rxd_sync_q  <= 2'b11;
      xcs_sync_q  <= 2'b11;
      xrd_sync_q  <= 2'b11;
      xwe_sync_q  <= 2'b11;
      cxcs_sync_q <= 2'b11;
      xd_sync1_q  <= '0;
      xd_sync2_q  <= '0;
    end else begin
      rxd_sync_q  <= {rxd_sync_q[0], uart_rxd};
      xcs_sync_q  <= {xcs_sync_q[0], xcs_n};
      xrd_sync_q  <= {xrd_sync_q[0], xrd};
      xwe_sync_q  <= {xwe_sync_q[0], xwe};
      cxcs_sync_q <= {cxcs_sync_q[0], c_xcs_n};
      xd_sync1_q  <= xdata[7:0];
      xd_sync2_q  <= xd_sync1_q;
    end
  end

  assign rxd_s  = rxd_sync_q[1];
  assign xrd_s  = xrd_sync_q[1];
  assign xwe_s  = xwe_sync_q[1];
  assign xif_en = !xcs_sync_q[1] && !cxcs_sync_q[1];

  // UART receiver
  rx_state_e  rx_state_q, rx_state_d;
  logic [6:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic       rx_byte_valid, rx_frame_err;

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_byte_valid = 1'b0;
    rx_frame_err  = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (!rxd_s) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
        end
      end
      RxStart: begin
        if (rx_cnt_q == BaudMid) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rxd_s ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + 7'd1;
        end
      end
      RxData: begin
        if (rx_cnt_q == BaudLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxd_s, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 7'd1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == BaudLast) begin
          rx_state_d    = RxIdle;
          rx_byte_valid = rxd_s;
          rx_frame_err  = !rxd_s;
        end else begin
          rx_cnt_d = rx_cnt_q + 7'd1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // Frame assembly: stage the whole frame, copy it into FIFO1 only once the checksum matches
  logic [7:0]       stage_q [U2X_FBYTE_NUM];
  logic [4:0]       idx_q, dump_idx_q;
  logic [7:0]       csum_q;
  logic             in_frame_q, dump_q;
  logic [7:0]       fifo1_rdata;
  logic [CNT_W-1:0] fifo1_count;
  logic             fifo1_empty, fifo1_pop;

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(U2X_FBYTE_NUM); i++) stage_q[i] <= '0;
      idx_q      <= '0;
      dump_idx_q <= '0;
      csum_q     <= '0;
      in_frame_q <= 1'b0;
      dump_q     <= 1'b0;
    end else begin
      if (dump_q) begin
        dump_idx_q <= dump_idx_q + 5'd1;
        if (dump_idx_q == FrameLast) dump_q <= 1'b0;
      end
      if (rx_frame_err) begin
        in_frame_q <= 1'b0;
      end else if (rx_byte_valid) begin
        if (!in_frame_q) begin
          if (rx_shift_q == FRAME_HEADER) begin
            stage_q[0] <= rx_shift_q;
            idx_q      <= 5'd1;
            csum_q     <= CSUM_SEED;
            in_frame_q <= 1'b1;
          end
        end else begin
          stage_q[idx_q] <= rx_shift_q;
          idx_q          <= idx_q + 5'd1;
          if (idx_q == FrameLast) begin
            in_frame_q <= 1'b0;
            if (rx_shift_q == csum_q && fifo1_count <= Fifo1Room && !dump_q) begin
              dump_q     <= 1'b1;
              dump_idx_q <= '0;
            end
          end else begin
            csum_q <= csum_q ^ rx_shift_q;
          end
        end
      end
    end
  end

  sync_fifo #(
    .Width (8),
    .Depth (FIFO_DEPTH),
    .CntW  (CNT_W)
  ) u_fifo1 (
    .clk   (clk50M),
    .rst_n (rst_n),
    .push  (dump_q),
    .wdata (stage_q[dump_idx_q]),
    .pop   (fifo1_pop),
    .rdata (fifo1_rdata),
    .count (fifo1_count),
    .empty (fifo1_empty)
  );

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) c_xrd_req <= 1'b0;
    else        c_xrd_req <= (fifo1_count >= FrameLen);
  end

  // XINTF side: an access is armed while enabled with the strobe low; the release pops/pushes
  logic       rd_armed_q, wr_armed_q, rd_drive, fifo2_push;
  logic [7:0] wr_byte_q;
  logic [15:0] rd_word;

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      rd_armed_q <= 1'b0;
      wr_armed_q <= 1'b0;
      wr_byte_q  <= '0;
    end else begin
      rd_armed_q <= xif_en && !xrd_s;
      wr_armed_q <= xif_en && !xwe_s;
      if (xif_en && !xwe_s) wr_byte_q <= xd_sync2_q;
    end
  end

  assign fifo1_pop  = rd_armed_q && xrd_s && xif_en;
  assign fifo2_push = wr_armed_q && xwe_s && xif_en;
  assign rd_drive   = xif_en && !xrd_s;
  assign rd_word    = fifo1_empty ? 16'h0000 : {8'h00, fifo1_rdata};
  assign xdata      = rd_drive ? rd_word : 16'hzzzz;

  // UART transmitter
  logic [7:0]       fifo2_rdata;
  logic [CNT_W-1:0] fifo2_count;
  logic             fifo2_empty, fifo2_pop;
  tx_state_e        tx_state_q, tx_state_d;
  logic [6:0]       tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d, tx_left_q, tx_left_d;
  logic [7:0]       tx_shift_q, tx_shift_d;

  sync_fifo #(
    .Width (8),
    .Depth (FIFO_DEPTH),
    .CntW  (CNT_W)
  ) u_fifo2 (
    .clk   (clk50M),
    .rst_n (rst_n),
    .push  (fifo2_push),
    .wdata (wr_byte_q),
    .pop   (fifo2_pop),
    .rdata (fifo2_rdata),
    .count (fifo2_count),
    .empty (fifo2_empty)
  );

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_left_q  <= '0;
      tx_shift_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_left_q  <= tx_left_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_left_d  = tx_left_q;
    tx_shift_d = tx_shift_q;
    fifo2_pop  = 1'b0;
    unique case (tx_state_q)
      TxIdle: begin
        // Mid-burst bytes continue unconditionally; a new burst needs a whole frame queued
        if ((tx_left_q != '0 && !fifo2_empty) || (tx_left_q == '0 && fifo2_count >= TxBurst)) begin
          fifo2_pop  = 1'b1;
          tx_shift_d = fifo2_rdata;
          tx_left_d  = (tx_left_q == '0) ? TxLeftInit : tx_left_q - 3'd1;
          tx_cnt_d   = '0;
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        if (tx_cnt_q == BaudLast) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TxData;
        end else begin
          tx_cnt_d = tx_cnt_q + 7'd1;
        end
      end
      TxData: begin
        if (tx_cnt_q == BaudLast) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) tx_state_d = TxStop;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt_q + 7'd1;
        end
      end
      TxStop: begin
        if (tx_cnt_q == BaudLast) tx_state_d = TxIdle;
        else                      tx_cnt_d   = tx_cnt_q + 7'd1;
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_comb begin
    unique case (tx_state_q)
      TxStart: uart_txd = 1'b0;
      TxData:  uart_txd = tx_shift_q[tx_bit_q];
      default: uart_txd = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_xintf_bridge.sv
// Scoreboard bench for uart_xintf_bridge: UART frames in, host reads out; host writes in, UART out.
module tb_uart_xintf_bridge;

  localparam int BIT = 109;
  localparam logic [7:0] PAYLOAD [20] = '{8'h02, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h10,
                                          8'hFF, 8'hFF, 8'h14, 8'h13, 8'h12, 8'h11, 8'h18,
                                          8'h17, 8'h16, 8'h15, 8'h20, 8'h19, 8'h21};

  logic        clk50M = 1'b0;
  logic        rst_n;
  logic        uart_rxd, xcs_n, xrd, xwe, c_xcs_n;
  wire         uart_txd, c_xrd_req;
  wire  [15:0] xdata;
  logic        tb_oe;
  logic [7:0]  tb_wdata;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  rx_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  frame_buf [22];
  bit          ignore_tx = 1'b0;
  bit          tx_low_seen = 1'b0;

  always #10 clk50M = ~clk50M;

  assign xdata = tb_oe ? {8'h00, tb_wdata} : 16'hzzzz;

  uart_xintf_bridge dut (
    .clk50M    (clk50M),
    .rst_n     (rst_n),
    .uart_rxd  (uart_rxd),
    .uart_txd  (uart_txd),
    .xcs_n     (xcs_n),
    .xrd       (xrd),
    .xwe       (xwe),
    .xdata     (xdata),
    .c_xcs_n   (c_xcs_n),
    .c_xrd_req (c_xrd_req)
  );

  always @(negedge uart_txd) tx_low_seen = 1'b1;

  // Decode every UART byte mid-bit and check it against the expected TX stream
  initial begin : tx_monitor
    logic [7:0] b, exp;
    forever begin
      @(negedge uart_txd);
      repeat (BIT / 2) @(negedge clk50M);
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge clk50M);
        b[i] = uart_txd;
      end
      repeat (BIT) @(negedge clk50M);
      if (!ignore_tx) begin
        checks++;
        if (uart_txd !== 1'b1) begin
          errors++;
          $display("FAIL tx_stop got %b want 1", uart_txd);
        end
        checks++;
        if (tx_q.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected got %02h want nothing", b);
        end else begin
          exp = tx_q.pop_front();
          if (b !== exp) begin
            errors++;
            $display("FAIL tx_byte got %02h want %02h", b, exp);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #4ms;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic uart_send_byte(input logic [7:0] b);
    uart_rxd = 1'b0;
    repeat (BIT) @(negedge clk50M);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (BIT) @(negedge clk50M);
    end
    uart_rxd = 1'b1;
    repeat (BIT) @(negedge clk50M);
  endtask

  task automatic make_frame(input bit corrupt);
    logic [7:0] cs;
    cs = 8'hFF;
    frame_buf[0] = 8'hAA;
    for (int i = 0; i < 20; i++) begin
      frame_buf[i + 1] = PAYLOAD[i];
      cs = cs ^ PAYLOAD[i];
    end
    frame_buf[21] = corrupt ? ~cs : cs;
  endtask

  task automatic xread(output logic [15:0] d);
    xcs_n = 1'b0;
    xrd   = 1'b0;
    repeat (5) @(negedge clk50M);
    d   = xdata;
    xrd = 1'b1;
    repeat (4) @(negedge clk50M);
    xcs_n = 1'b1;
    repeat (3) @(negedge clk50M);
  endtask

  task automatic xwrite(input logic [7:0] v);
    xcs_n    = 1'b0;
    tb_wdata = v;
    tb_oe    = 1'b1;
    xwe      = 1'b0;
    repeat (5) @(negedge clk50M);
    xwe = 1'b1;
    repeat (4) @(negedge clk50M);
    xcs_n = 1'b1;
    tb_oe = 1'b0;
    repeat (3) @(negedge clk50M);
  endtask

  task automatic read_expect(input string name);
    logic [15:0] d, exp;
    if (rx_q.size() != 0) exp = {8'h00, rx_q.pop_front()};
    else                  exp = 16'h0000;
    xread(d);
    checks++;
    if (d !== exp) begin
      errors++;
      $display("FAIL %s got %04h want %04h", name, d, exp);
    end
  endtask

  task automatic wait_tx_drain(input int budget, input string name);
    int n;
    n = 0;
    while (tx_q.size() != 0 && n < budget) begin
      @(negedge clk50M);
      n++;
    end
    checks++;
    if (tx_q.size() != 0) begin
      errors++;
      $display("FAIL %s got %0d bytes pending want 0", name, tx_q.size());
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk50M);
    checks++;
    if (uart_txd !== 1'b1) begin errors++; $display("FAIL rst_txd got %b want 1", uart_txd); end
    checks++;
    if (c_xrd_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", c_xrd_req); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk50M);
    checks++;
    if (uart_txd !== 1'b1) begin errors++; $display("FAIL post_rst_txd got %b want 1", uart_txd); end
    checks++;
    if (c_xrd_req !== 1'b0) begin errors++; $display("FAIL post_rst_req got %b want 0", c_xrd_req); end
  endtask

  task automatic test_rx_frame;
    make_frame(1'b0);
    for (int i = 0; i < 22; i++) rx_q.push_back(frame_buf[i]);
    for (int i = 0; i < 21; i++) uart_send_byte(frame_buf[i]);
    checks++;
    if (c_xrd_req !== 1'b0) begin errors++; $display("FAIL rx_req_early got %b want 0", c_xrd_req); end
    uart_send_byte(frame_buf[21]);
    repeat (3) @(negedge clk50M);
    checks++;
    if (c_xrd_req !== 1'b1) begin errors++; $display("FAIL rx_req_rise got %b want 1", c_xrd_req); end
    read_expect("rx_read");
    repeat (3) @(negedge clk50M);
    checks++;
    if (c_xrd_req !== 1'b0) begin errors++; $display("FAIL rx_req_drop got %b want 0", c_xrd_req); end
    for (int i = 1; i < 22; i++) read_expect("rx_read");
    read_expect("rx_read_empty");
  endtask

  task automatic test_tx;
    for (int i = 0; i < 6; i++) begin
      tx_q.push_back(8'h50 + 8'(i));
      xwrite(8'h50 + 8'(i));
    end
    wait_tx_drain(8000, "tx_drain");
    checks++;
    if (uart_txd !== 1'b1) begin errors++; $display("FAIL tx_idle got %b want 1", uart_txd); end
  endtask

  task automatic test_bad_csum;
    make_frame(1'b1);
    for (int i = 0; i < 22; i++) uart_send_byte(frame_buf[i]);
    repeat (3) @(negedge clk50M);
    checks++;
    if (c_xrd_req !== 1'b0) begin errors++; $display("FAIL bad_csum_req got %b want 0", c_xrd_req); end
    read_expect("bad_csum_empty");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++) begin
      tx_q.push_back(8'h58 + 8'(i));
      xwrite(8'h58 + 8'(i));
    end
    repeat (300) @(negedge clk50M);
    for (int i = 0; i < 6; i++) begin
      tx_q.push_back(8'h60 + 8'(i));
      xwrite(8'h60 + 8'(i));
    end
    wait_tx_drain(15000, "b2b_drain");
  endtask

  task automatic test_reset_mid;
    ignore_tx = 1'b1;
    for (int i = 0; i < 6; i++) xwrite(8'h70 + 8'(i));
    make_frame(1'b0);
    for (int i = 0; i < 3; i++) uart_send_byte(frame_buf[i]);
    uart_rxd = 1'b0;
    repeat (200) @(negedge clk50M);
    rst_n = 1'b0;
    #1;
    checks++;
    if (uart_txd !== 1'b1) begin errors++; $display("FAIL mid_rst_txd got %b want 1", uart_txd); end
    checks++;
    if (c_xrd_req !== 1'b0) begin errors++; $display("FAIL mid_rst_req got %b want 0", c_xrd_req); end
    repeat (5) @(negedge clk50M);
    rst_n    = 1'b1;
    uart_rxd = 1'b1;
    repeat (1500) @(negedge clk50M);
    tx_q.delete();
    ignore_tx = 1'b0;
    checks++;
    if (uart_txd !== 1'b1) begin errors++; $display("FAIL mid_rst_idle got %b want 1", uart_txd); end
    read_expect("mid_rst_fifo1_empty");
  endtask

  task automatic test_disabled;
    logic [15:0] d;
    c_xcs_n     = 1'b1;
    tx_low_seen = 1'b0;
    for (int i = 0; i < 6; i++) xwrite(8'h50 + 8'(i));
    make_frame(1'b0);
    for (int i = 0; i < 22; i++) rx_q.push_back(frame_buf[i]);
    for (int i = 0; i < 22; i++) uart_send_byte(frame_buf[i]);
    repeat (3) @(negedge clk50M);
    checks++;
    if (tx_low_seen !== 1'b0) begin errors++; $display("FAIL dis_txd got activity want idle"); end
    checks++;
    if (c_xrd_req !== 1'b1) begin errors++; $display("FAIL dis_req got %b want 1", c_xrd_req); end
    xread(d);
    checks++;
    if (d === 16'h00AA) begin errors++; $display("FAIL dis_read_driven got %04h want undriven", d); end
    repeat (3) @(negedge clk50M);
    checks++;
    if (c_xrd_req !== 1'b1) begin errors++; $display("FAIL dis_req_hold got %b want 1", c_xrd_req); end
    c_xcs_n = 1'b0;
    repeat (3) @(negedge clk50M);
    for (int i = 0; i < 22; i++) read_expect("dis_read");
    repeat (3) @(negedge clk50M);
    checks++;
    if (c_xrd_req !== 1'b0) begin errors++; $display("FAIL dis_req_final got %b want 0", c_xrd_req); end
  endtask

  initial begin
    rst_n    = 1'b1;
    uart_rxd = 1'b1;
    xcs_n    = 1'b1;
    xrd      = 1'b1;
    xwe      = 1'b1;
    c_xcs_n  = 1'b0;
    tb_oe    = 1'b0;
    tb_wdata = 8'h00;
    #5 rst_n = 1'b0;
    test_reset();
    // UART RX traffic and XINTF writes use disjoint pins, so they overlap to save run time
    fork
      test_rx_frame();
      test_tx();
    join
    fork
      test_bad_csum();
      test_back_to_back();
    join
    test_reset_mid();
    test_disabled();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
